demux_banco_reg: RTL and testbench
==================================

# demux_banco_reg

Write-side distributor for the datapath register bank: accepts one WIDTH-bit word per handshake and steers it, via a 1-to-N demultiplexer, into one of N holding registers. Every register not addressed holds its value. Two modes: addressed (caller supplies the index) and sequential (internal pointer auto-increments and stalls when the bank is full until drained). Sits between the ALU result path and the operand/result registers that feed the ALU inputs.

## Interface
- WIDTH, 8, data width of each register
- N_REGS, 4, number of registers; power of two, ≥2
- ADDR_W, $clog2(N_REGS), index width (derived, not overridden)

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  write request
- in_ready  out  1  block can accept; a write occurs when in_valid && in_ready at clk rise
- in_data  in  WIDTH  word to store
- in_addr  in  ADDR_W  target index (addressed mode only)
- modo_seq  in  1  0 = addressed, 1 = sequential
- drain  in  1  consumer has taken the bank; clear flags, reset pointer
- clear  in  1  synchronous zero of registers, flags, pointer
- q  out  N_REGS*WIDTH  register contents, register i at bits [i*WIDTH +: WIDTH]
- wr_strobe  out  N_REGS  one-hot, one-cycle pulse of the register written this cycle (registered)
- loaded  out  N_REGS  sticky per-register "written since last drain/clear"
- all_loaded  out  1  &loaded
- ptr  out  ADDR_W  current sequential pointer

## Operation
- Reset (rst_n low, async): q=0, loaded=0, wr_strobe=0, ptr=0, all_loaded=0.
- Priority each cycle: clear > drain > write.
- clear: q=0, loaded=0, ptr=0, wr_strobe=0; in_ready=0 that cycle.
- drain: loaded=0, ptr=0, q unchanged, wr_strobe=0; in_ready=0 that cycle.
- in_ready = !clear && !drain && !(modo_seq && all_loaded). Combinational from current state and inputs; does not depend on in_valid.
- Write target: in_addr if modo_seq=0, else ptr.
- On write: q[target]=in_data; loaded[target]=1; wr_strobe next cycle = one-hot(target); others 0.
- Sequential mode: ptr increments after each write; wraps N_REGS-1 → 0. After the Nth write all_loaded=1 and in_ready drops until drain/clear.
- Addressed mode: ptr unchanged by writes; rewriting an index overwrites and leaves loaded set; never stalls even when all_loaded.
- modo_seq change between writes is legal; ptr keeps its value.
- in_addr/in_data ignored when no write occurs.

## Timing
- Write latency: q and loaded reflect the word on the first clk rise with in_valid && in_ready; wr_strobe high in the cycle following that edge, for exactly one cycle.
- Back-to-back writes every cycle supported (full throughput) until stall.
- all_loaded is combinational from loaded; in_ready may fall in the same cycle all_loaded rises.
- rst_n assertion mid-stream aborts immediately; a write on the same edge as reset release is ignored only if rst_n still low at that edge.

## Structure
- Shared package: WIDTH default, N_REGS default, mode encoding constants MODO_END=0, MODO_SEQ=1.
- Sub-module demux_1paraN: combinational, one-hot enable from ADDR_W index gated by write; each register bit selects load vs hold from its enable.
- Pointer, flags and strobe register live in the top.

## Test plan
- Reset: rst_n low with clk running → q=0, loaded=0000, ptr=0, in_ready=1 after release.
- Addressed: write 0x3C to addr 2, then 0xA5 to addr 2 → q[2]=0xA5, loaded=0100, wr_strobe=0100 each cycle after write, other registers 0.
- Sequential fill: modo_seq=1, write 0x11,0x22,0x33,0x44 back-to-back → q={0x44,0x33,0x22,0x11}, all_loaded=1, in_ready=0; fifth word 0x55 held with in_valid high not accepted.
- Drain then resume: after fill, pulse drain with in_valid=1 → no write that cycle, loaded=0, ptr=0, q unchanged; next cycle 0x55 lands in q[0].
- Clear vs write: clear=1 and in_valid=1 same cycle → q all 0, wr_strobe=0, loaded=0.
- Async reset mid-fill: after two sequential writes, drop rst_n between edges → outputs zero immediately, ptr=0.

Source files
------------

// File: rtl/demux_banco_reg_pkg.sv
// Shared defaults and mode encoding for the register-bank write distributor.
package demux_banco_reg_pkg;

  localparam int unsigned WIDTH_DEF  = 8;
  localparam int unsigned N_REGS_DEF = 4;

  typedef enum logic {
    MODO_END = 1'b0,
    MODO_SEQ = 1'b1
  } modo_t;

endpackage

// File: rtl/demux_banco_reg_if.sv
// Write handshake into the register bank: producer drives word/index, bank returns ready.
interface demux_banco_reg_if
  import demux_banco_reg_pkg::*;
#(
  parameter int unsigned WIDTH  = WIDTH_DEF,
  parameter int unsigned N_REGS = N_REGS_DEF
);

  localparam int unsigned ADDR_W = $clog2(N_REGS);

  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_data;
  logic [ADDR_W-1:0] in_addr;

  modport master (output in_valid, output in_data, output in_addr, input in_ready);
  modport slave  (input in_valid, input in_data, input in_addr, output in_ready);

endinterface

// File: rtl/demux_banco_reg_demux_1paraN.sv
// 1-to-N write demultiplexer: one-hot enable from the index, per-register load/hold select.
module demux_1paraN
  import demux_banco_reg_pkg::*;
#(
  parameter int unsigned WIDTH  = WIDTH_DEF,
  parameter int unsigned N_REGS = N_REGS_DEF
) (
  input  logic                       wr,
  input  logic [$clog2(N_REGS)-1:0]  idx,
  input  logic [WIDTH-1:0]           d,
  input  logic [N_REGS*WIDTH-1:0]    q_cur,
  output logic [N_REGS-1:0]          en,
  output logic [N_REGS*WIDTH-1:0]    q_next
);

  localparam int unsigned ADDR_W = $clog2(N_REGS);

  always_comb begin
    en     = '0;
    q_next = q_cur;
    for (int unsigned i = 0; i < N_REGS; i++) begin
      en[i] = wr && (idx == ADDR_W'(i));
      if (en[i]) begin
        q_next[i*WIDTH +: WIDTH] = d;
      end
    end
  end

endmodule

// File: rtl/demux_banco_reg.sv
// Register-bank write distributor: addressed or auto-incrementing sequential fill,
// with sticky per-register loaded flags and a registered one-hot write strobe.
module demux_banco_reg
  import demux_banco_reg_pkg::*;
#(
  parameter int unsigned WIDTH  = WIDTH_DEF,
  parameter int unsigned N_REGS = N_REGS_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  demux_banco_reg_if.slave           bus,
  input  logic                       modo_seq,
  input  logic                       drain,
  input  logic                       clear,
  output logic [N_REGS*WIDTH-1:0]    q,
  output logic [N_REGS-1:0]          wr_strobe,
  output logic [N_REGS-1:0]          loaded,
  output logic                       all_loaded,
  output logic [$clog2(N_REGS)-1:0]  ptr
);

  localparam int unsigned ADDR_W = $clog2(N_REGS);

  logic                    seq_mode;
  logic                    wr_fire;
  logic [ADDR_W-1:0]       target;
  logic [N_REGS-1:0]       en;
  logic [N_REGS*WIDTH-1:0] q_next;

  assign seq_mode     = (modo_seq == MODO_SEQ);
  assign all_loaded   = &loaded;
  // Only sequential mode stalls on a full bank; addressed writes may always overwrite.
  assign bus.in_ready = !clear && !drain && !(seq_mode && all_loaded);
  assign wr_fire      = bus.in_valid && bus.in_ready;
  assign target       = seq_mode ? ptr : bus.in_addr;

  demux_1paraN #(
    .WIDTH  (WIDTH),
    .N_REGS (N_REGS)
  ) u_demux (
    .wr     (wr_fire),
    .idx    (target),
    .d      (bus.in_data),
    .q_cur  (q),
    .en     (en),
    .q_next (q_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q         <= '0;
      loaded    <= '0;
      wr_strobe <= '0;
      ptr       <= '0;
    end else if (clear) begin
      q         <= '0;
      loaded    <= '0;
      wr_strobe <= '0;
      ptr       <= '0;
    end else if (drain) begin
      loaded    <= '0;
      wr_strobe <= '0;
      ptr       <= '0;
    end else begin
      q         <= q_next;
      loaded    <= loaded | en;
      wr_strobe <= en;
      if (wr_fire && seq_mode) begin
        ptr <= ptr + ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_demux_banco_reg.sv
// Vector table plus scoreboard of pending writes for demux_banco_reg (WIDTH=8, N_REGS=4).
module tb_demux_banco_reg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        modo_seq = 1'b0;
  logic        drain = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] q;
  logic [3:0]  wr_strobe;
  logic [3:0]  loaded;
  logic        all_loaded;
  logic [1:0]  ptr;

  int n_tests = 0;
  int n_fail  = 0;

  demux_banco_reg_if #(.WIDTH(8), .N_REGS(4)) bus ();

  demux_banco_reg #(.WIDTH(8), .N_REGS(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .modo_seq   (modo_seq),
    .drain      (drain),
    .clear      (clear),
    .q          (q),
    .wr_strobe  (wr_strobe),
    .loaded     (loaded),
    .all_loaded (all_loaded),
    .ptr        (ptr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic [1:0]  a;
    logic        seq;
    logic        drn;
    logic        clr;
    logic        rdy;
    logic [1:0]  tgt;
    logic [31:0] eq;
    logic [3:0]  eld;
    logic [1:0]  ep;
  } vec_t;

  typedef struct {
    logic [1:0] tgt;
    logic [7:0] d;
  } sb_t;

  sb_t  sb[$];
  vec_t tbl[16];

  function automatic vec_t mk(logic v, logic [7:0] d, logic [1:0] a, logic seq, logic drn,
                              logic clr, logic rdy, logic [1:0] tgt, logic [31:0] eq,
                              logic [3:0] eld, logic [1:0] ep);
    vec_t r;
    r.v = v; r.d = d; r.a = a; r.seq = seq; r.drn = drn; r.clr = clr;
    r.rdy = rdy; r.tgt = tgt; r.eq = eq; r.eld = eld; r.ep = ep;
    return r;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_scoreboard(string tag);
    sb_t        e;
    logic [3:0] oh;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      oh = '0;
      oh[e.tgt] = 1'b1;
      check({tag, ".wr_strobe"}, 32'(wr_strobe), 32'(oh));
      check({tag, ".q_slot"}, 32'(q[e.tgt*8 +: 8]), 32'(e.d));
    end else begin
      check({tag, ".wr_strobe_idle"}, 32'(wr_strobe), 32'h0);
    end
  endtask

  task automatic apply(vec_t t, string tag);
    sb_t e;
    @(negedge clk);
    bus.in_valid = t.v;
    bus.in_data  = t.d;
    bus.in_addr  = t.a;
    modo_seq     = t.seq;
    drain        = t.drn;
    clear        = t.clr;
    #1;
    check({tag, ".in_ready"}, 32'(bus.in_ready), 32'(t.rdy));
    if (t.rdy && t.v) begin
      e.tgt = t.tgt;
      e.d   = t.d;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    check({tag, ".q"}, q, t.eq);
    check({tag, ".loaded"}, 32'(loaded), 32'(t.eld));
    check({tag, ".all_loaded"}, 32'(all_loaded), 32'(&t.eld));
    check({tag, ".ptr"}, 32'(ptr), 32'(t.ep));
    check_scoreboard(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin
    //            v  d      a  seq drn clr rdy tgt q             loaded   ptr
    tbl[0]  = mk(1, 8'h3C, 2, 0,  0,  0,  1,  2, 32'h003C0000, 4'b0100, 0);
    tbl[1]  = mk(1, 8'hA5, 2, 0,  0,  0,  1,  2, 32'h00A50000, 4'b0100, 0);
    tbl[2]  = mk(0, 8'hFF, 1, 0,  0,  0,  1,  1, 32'h00A50000, 4'b0100, 0);
    tbl[3]  = mk(1, 8'h77, 0, 0,  0,  1,  0,  0, 32'h00000000, 4'b0000, 0);
    tbl[4]  = mk(1, 8'h11, 3, 1,  0,  0,  1,  0, 32'h00000011, 4'b0001, 1);
    tbl[5]  = mk(1, 8'h22, 3, 1,  0,  0,  1,  1, 32'h00002211, 4'b0011, 2);
    tbl[6]  = mk(1, 8'h33, 0, 1,  0,  0,  1,  2, 32'h00332211, 4'b0111, 3);
    tbl[7]  = mk(1, 8'h44, 0, 1,  0,  0,  1,  3, 32'h44332211, 4'b1111, 0);
    tbl[8]  = mk(1, 8'h55, 0, 1,  0,  0,  0,  0, 32'h44332211, 4'b1111, 0);
    tbl[9]  = mk(1, 8'h55, 2, 1,  0,  0,  0,  0, 32'h44332211, 4'b1111, 0);
    tbl[10] = mk(1, 8'h99, 1, 0,  0,  0,  1,  1, 32'h44339911, 4'b1111, 0);
    tbl[11] = mk(1, 8'h66, 0, 1,  1,  0,  0,  0, 32'h44339911, 4'b0000, 0);
    tbl[12] = mk(1, 8'h55, 2, 1,  0,  0,  1,  0, 32'h44339955, 4'b0001, 1);
    tbl[13] = mk(1, 8'hE7, 3, 0,  0,  0,  1,  3, 32'hE7339955, 4'b1001, 1);
    tbl[14] = mk(1, 8'h12, 0, 1,  0,  0,  1,  1, 32'hE7331255, 4'b1011, 2);
    tbl[15] = mk(1, 8'hC3, 1, 0,  1,  1,  0,  0, 32'h00000000, 4'b0000, 0);

    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_addr  = 2'd0;

    // Reset held with clock running
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.q", q, 32'h0);
    check("rst.loaded", 32'(loaded), 32'h0);
    check("rst.ptr", 32'(ptr), 32'h0);
    check("rst.wr_strobe", 32'(wr_strobe), 32'h0);
    check("rst.all_loaded", 32'(all_loaded), 32'h0);
    rst_n = 1'b1;
    #1;
    check("rst.in_ready", 32'(bus.in_ready), 32'h1);

    for (int i = 0; i < 16; i++) begin
      apply(tbl[i], $sformatf("vec%0d", i));
    end

    // Async reset mid-fill: two sequential writes, then reset between edges
    apply(mk(1, 8'hA1, 0, 1, 0, 0, 1, 0, 32'h000000A1, 4'b0001, 1), "mid0");
    apply(mk(1, 8'hB2, 0, 1, 0, 0, 1, 1, 32'h0000B2A1, 4'b0011, 2), "mid1");
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.q", q, 32'h0);
    check("arst.loaded", 32'(loaded), 32'h0);
    check("arst.ptr", 32'(ptr), 32'h0);
    check("arst.wr_strobe", 32'(wr_strobe), 32'h0);

    // Write offered while reset is still low at the edge must be dropped
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h5A;
    modo_seq     = 1'b0;
    bus.in_addr  = 2'd1;
    @(posedge clk);
    #1;
    check("rstedge.q", q, 32'h0);
    check("rstedge.loaded", 32'(loaded), 32'h0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;

    apply(mk(1, 8'h5A, 1, 0, 0, 0, 1, 1, 32'h00005A00, 4'b0010, 0), "post");
    apply(mk(0, 8'h00, 0, 0, 0, 0, 1, 0, 32'h00005A00, 4'b0010, 0), "idle");

    check("sb.empty", 32'(sb.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
